// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
// Shared constants for the bus-CPU control unit:
//   - opcode encodings (upper nibble of IR)
//   - T-state encodings for the step counter
//   - control-word bit indices (all bits active-high internally) and the
//     all-inactive control word
package control_sequencer_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int STEP_WIDTH   = 3;

    // Opcodes
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

    // T-states
    localparam logic [STEP_WIDTH-1:0] T0       = 3'd0;
    localparam logic [STEP_WIDTH-1:0] T1       = 3'd1;
    localparam logic [STEP_WIDTH-1:0] T2       = 3'd2;
    localparam logic [STEP_WIDTH-1:0] T3       = 3'd3;
    localparam logic [STEP_WIDTH-1:0] T4       = 3'd4;
    localparam logic [STEP_WIDTH-1:0] STEP_ONE = 3'd1;

    // Control-word bit indices (1 = line asserted, polarity fixed at the top)
    localparam int CW_PC_OUT   = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_PC_LOAD  = 2;
    localparam int CW_MAR_IN   = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_RAM_IN   = 5;
    localparam int CW_IR_IN    = 6;
    localparam int CW_IR_OUT   = 7;
    localparam int CW_A_IN     = 8;
    localparam int CW_A_OUT    = 9;
    localparam int CW_B_IN     = 10;
    localparam int CW_ALU_OUT  = 11;
    localparam int CW_SUB      = 12;
    localparam int CW_FLAGS_IN = 13;
    localparam int CW_OUT_IN   = 14;
    localparam int CW_HALT     = 15;
    localparam int CW_WIDTH    = 16;

    typedef logic [CW_WIDTH-1:0] ctrl_word_t;

    localparam ctrl_word_t CW_INACTIVE = '0;

    // Single-bit control word, used to build the halted output word.
    function automatic ctrl_word_t cw_bit(input int idx);
        ctrl_word_t w;
        w      = CW_INACTIVE;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
// Groups the sequencer's datapath-facing signals.
//   master: the sequencer (reads opcode/flags, drives step and control lines)
//   slave : the datapath   (drives opcode/flags, reads step and control lines)
// There is no valid/ready handshake here: every control line is a level
// that is meaningful for exactly one clock cycle (the current T-state) and
// is acted on by the receiving register at the rising edge ending that cycle.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [OPCODE_WIDTH-1:0] i_OPCODE;
    logic                    i_ZERO_FLAG;
    logic                    i_CARRY_FLAG;

    logic [STEP_WIDTH-1:0]   o_STEP;
    logic o_PC_OUT_n;
    logic o_PC_INC;
    logic o_PC_LOAD_n;
    logic o_MAR_IN_n;
    logic o_RAM_OUT_n;
    logic o_RAM_IN_n;
    logic o_IR_IN_n;
    logic o_IR_OUT_n;
    logic o_A_IN_n;
    logic o_A_OUT_n;
    logic o_B_IN_n;
    logic o_ALU_OUT_n;
    logic o_SUB;
    logic o_FLAGS_IN_n;
    logic o_OUT_IN_n;
    logic o_HALT;

    modport master (
        input  i_OPCODE, i_ZERO_FLAG, i_CARRY_FLAG,
        output o_STEP, o_PC_OUT_n, o_PC_INC, o_PC_LOAD_n, o_MAR_IN_n,
               o_RAM_OUT_n, o_RAM_IN_n, o_IR_IN_n, o_IR_OUT_n, o_A_IN_n,
               o_A_OUT_n, o_B_IN_n, o_ALU_OUT_n, o_SUB, o_FLAGS_IN_n,
               o_OUT_IN_n, o_HALT
    );

    modport slave (
        output i_OPCODE, i_ZERO_FLAG, i_CARRY_FLAG,
        input  o_STEP, o_PC_OUT_n, o_PC_INC, o_PC_LOAD_n, o_MAR_IN_n,
               o_RAM_OUT_n, o_RAM_IN_n, o_IR_IN_n, o_IR_OUT_n, o_A_IN_n,
               o_A_OUT_n, o_B_IN_n, o_ALU_OUT_n, o_SUB, o_FLAGS_IN_n,
               o_OUT_IN_n, o_HALT
    );

endinterface

// File: rtl/control_microcode_rom.sv
// control_microcode_rom
// Purely combinational microcode: (step, opcode, zero, carry) -> control
// word plus a last-step bit that tells the sequencer to wrap to T0.
// Ports:
//   step      in  current T-state
//   opcode    in  opcode nibble
//   zero_flag in  registered ALU zero flag (only looked at in T2)
//   carry_flag in registered ALU carry flag (only looked at in T2)
//   cw        out active-high control word
//   last      out this step is the final step of the instruction
module control_microcode_rom
    import control_sequencer_pkg::*;
(
    input  logic [STEP_WIDTH-1:0]   step,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero_flag,
    input  logic                    carry_flag,
    output ctrl_word_t              cw,
    output logic                    last
);

    always_comb begin
        cw   = CW_INACTIVE;
        last = 1'b0;
        case (step)
            T0: begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_IN] = 1'b1;
            end
            T1: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_IN]   = 1'b1;
                cw[CW_PC_INC]  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_A_IN]   = 1'b1;
                        last          = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = 1'b1;
                        last           = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = carry_flag;
                        last           = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = zero_flag;
                        last           = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_OUT_IN] = 1'b1;
                        last          = 1'b1;
                    end
                    // HLT never wraps; the sequencer freezes on this step.
                    OP_HLT: cw[CW_HALT] = 1'b1;
                    // NOP and the undefined opcodes end here with no lines.
                    default: last = 1'b1;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
                        last           = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_IN]    = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_RAM_IN] = 1'b1;
                        last          = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT]  = 1'b1;
                    cw[CW_A_IN]     = 1'b1;
                    cw[CW_FLAGS_IN] = 1'b1;
                    cw[CW_SUB]      = (opcode == OP_SUB);
                end
                last = 1'b1;
            end
            // Steps 5-7 cannot be reached; if they are, stay quiet and wrap.
            default: last = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Microcoded control unit for the 8-bit bus CPU. Holds the T-state counter
// and a halted bit, decodes the control word through control_microcode_rom
// and unpacks it onto the (mostly active-low) control lines.
// Ports:
//   i_CLOCK  in  system clock, rising edge
//   i_CLEAR  in  asynchronous active-high reset
//   bus      master modport: opcode/flags in, o_STEP and control lines out
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                 i_CLOCK,
    input  logic                 i_CLEAR,
    control_sequencer_if.master  bus
);

    logic [STEP_WIDTH-1:0] step;
    logic                  halted;
    ctrl_word_t            rom_cw;
    logic                  rom_last;
    ctrl_word_t            cw;

    control_microcode_rom u_rom (
        .step       (step),
        .opcode     (bus.i_OPCODE),
        .zero_flag  (bus.i_ZERO_FLAG),
        .carry_flag (bus.i_CARRY_FLAG),
        .cw         (rom_cw),
        .last       (rom_last)
    );

    // HALT in T2 takes priority over wrapping: the step stays at T2 and the
    // halted bit latches so later opcode changes cannot restart execution.
    always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            step   <= T0;
            halted <= 1'b0;
        end else if (halted) begin
            step   <= step;
        end else if (step == T2 && rom_cw[CW_HALT]) begin
            halted <= 1'b1;
        end else if (rom_last) begin
            step   <= T0;
        end else begin
            step   <= step + STEP_ONE;
        end
    end

    // While halted only the halt request is driven, whatever the opcode.
    assign cw = halted ? cw_bit(CW_HALT) : rom_cw;

    assign bus.o_STEP       = step;
    assign bus.o_PC_OUT_n   = ~cw[CW_PC_OUT];
    assign bus.o_PC_INC     =  cw[CW_PC_INC];
    assign bus.o_PC_LOAD_n  = ~cw[CW_PC_LOAD];
    assign bus.o_MAR_IN_n   = ~cw[CW_MAR_IN];
    assign bus.o_RAM_OUT_n  = ~cw[CW_RAM_OUT];
    assign bus.o_RAM_IN_n   = ~cw[CW_RAM_IN];
    assign bus.o_IR_IN_n    = ~cw[CW_IR_IN];
    assign bus.o_IR_OUT_n   = ~cw[CW_IR_OUT];
    assign bus.o_A_IN_n     = ~cw[CW_A_IN];
    assign bus.o_A_OUT_n    = ~cw[CW_A_OUT];
    assign bus.o_B_IN_n     = ~cw[CW_B_IN];
    assign bus.o_ALU_OUT_n  = ~cw[CW_ALU_OUT];
    assign bus.o_SUB        =  cw[CW_SUB];
    assign bus.o_FLAGS_IN_n = ~cw[CW_FLAGS_IN];
    assign bus.o_OUT_IN_n   = ~cw[CW_OUT_IN];
    assign bus.o_HALT       =  cw[CW_HALT];

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Directed plus randomized instruction stream. The reference model expands
// each instruction into its list of micro-operations (names of asserted
// control lines per T-state); the bench turns the DUT's pins back into the
// same textual form each cycle and compares.
module tb_control_sequencer;

    logic i_CLOCK = 1'b0;
    logic i_CLEAR;

    control_sequencer_if bus ();

    control_sequencer dut (
        .i_CLOCK (i_CLOCK),
        .i_CLEAR (i_CLEAR),
        .bus     (bus)
    );

    // Clock / reset
    always #5 i_CLOCK = ~i_CLOCK;

    int checks = 0;
    int errors = 0;

    // Expected micro-op list of the instruction in flight, one entry per step.
    string exp_q[$];

    function automatic string join_name(input string s, input string n);
        return (s.len() == 0) ? n : {s, " ", n};
    endfunction

    // DUT pins -> canonical list of asserted lines.
    function automatic string observed();
        string s;
        s = "";
        if (!bus.o_PC_OUT_n)   s = join_name(s, "PC_OUT");
        if (bus.o_PC_INC)      s = join_name(s, "PC_INC");
        if (!bus.o_PC_LOAD_n)  s = join_name(s, "PC_LOAD");
        if (!bus.o_MAR_IN_n)   s = join_name(s, "MAR_IN");
        if (!bus.o_RAM_OUT_n)  s = join_name(s, "RAM_OUT");
        if (!bus.o_RAM_IN_n)   s = join_name(s, "RAM_IN");
        if (!bus.o_IR_IN_n)    s = join_name(s, "IR_IN");
        if (!bus.o_IR_OUT_n)   s = join_name(s, "IR_OUT");
        if (!bus.o_A_IN_n)     s = join_name(s, "A_IN");
        if (!bus.o_A_OUT_n)    s = join_name(s, "A_OUT");
        if (!bus.o_B_IN_n)     s = join_name(s, "B_IN");
        if (!bus.o_ALU_OUT_n)  s = join_name(s, "ALU_OUT");
        if (bus.o_SUB)         s = join_name(s, "SUB");
        if (!bus.o_FLAGS_IN_n) s = join_name(s, "FLAGS_IN");
        if (!bus.o_OUT_IN_n)   s = join_name(s, "OUT_IN");
        if (bus.o_HALT)        s = join_name(s, "HALT");
        return s;
    endfunction

    // Reference model: instruction -> sequence of micro-op sets.
    task automatic load_program(input logic [3:0] op, input logic z, input logic c);
        exp_q.delete();
        exp_q.push_back("PC_OUT MAR_IN");
        exp_q.push_back("PC_INC RAM_OUT IR_IN");
        case (op)
            4'h1: begin
                exp_q.push_back("MAR_IN IR_OUT");
                exp_q.push_back("RAM_OUT A_IN");
            end
            4'h2: begin
                exp_q.push_back("MAR_IN IR_OUT");
                exp_q.push_back("RAM_OUT B_IN");
                exp_q.push_back("A_IN ALU_OUT FLAGS_IN");
            end
            4'h3: begin
                exp_q.push_back("MAR_IN IR_OUT");
                exp_q.push_back("RAM_OUT B_IN");
                exp_q.push_back("A_IN ALU_OUT SUB FLAGS_IN");
            end
            4'h4: begin
                exp_q.push_back("MAR_IN IR_OUT");
                exp_q.push_back("RAM_IN A_OUT");
            end
            4'h5: exp_q.push_back("IR_OUT A_IN");
            4'h6: exp_q.push_back("PC_LOAD IR_OUT");
            4'h7: exp_q.push_back(c ? "PC_LOAD IR_OUT" : "IR_OUT");
            4'h8: exp_q.push_back(z ? "PC_LOAD IR_OUT" : "IR_OUT");
            4'hE: exp_q.push_back("A_OUT OUT_IN");
            4'hF: exp_q.push_back("HALT");
            default: exp_q.push_back("");
        endcase
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag);
        int n;
        n = int'(!bus.o_PC_OUT_n) + int'(!bus.o_RAM_OUT_n) + int'(!bus.o_IR_OUT_n)
          + int'(!bus.o_A_OUT_n) + int'(!bus.o_ALU_OUT_n);
        checks++;
        assert (n <= 1) else begin
            errors++;
            $error("FAIL %s bus_drivers: observed %0d expected <=1", tag, n);
        end
    endtask

    // Driver: called at a falling edge with step expected at 0. Runs up to n
    // steps of the instruction, checking each, and returns at the following
    // falling edge.
    task automatic run_instr(input logic [3:0] op, input logic z, input logic c, input int n);
        string tag;
        bus.i_OPCODE     = op;
        bus.i_ZERO_FLAG  = z;
        bus.i_CARRY_FLAG = c;
        load_program(op, z, c);
        for (int s = 0; s < exp_q.size() && s < n; s++) begin
            if (s > 0) @(negedge i_CLOCK);
            #1;
            tag = $sformatf("op%0h_t%0d", op, s);
            check_int({tag, "_step"}, int'(bus.o_STEP), s);
            check_str({tag, "_lines"}, observed(), exp_q[s]);
            check_bus(tag);
        end
        @(negedge i_CLOCK);
    endtask

    task automatic run_full(input logic [3:0] op, input logic z, input logic c);
        run_instr(op, z, c, 8);
    endtask

    logic [3:0] rop;

    initial begin
        bus.i_OPCODE     = 4'h0;
        bus.i_ZERO_FLAG  = 1'b0;
        bus.i_CARRY_FLAG = 1'b0;
        i_CLEAR          = 1'b1;

        // Reset state
        #2;
        check_int("reset_step", int'(bus.o_STEP), 0);
        check_str("reset_lines", observed(), "PC_OUT MAR_IN");
        @(negedge i_CLOCK);
        i_CLEAR = 1'b0;

        // ADD, SUB, conditional jumps both ways, undefined opcode
        run_full(4'h2, 1'b0, 1'b0);
        run_full(4'h3, 1'b1, 1'b1);
        run_full(4'h7, 1'b1, 1'b0);
        run_full(4'h7, 1'b0, 1'b1);
        run_full(4'h8, 1'b0, 1'b1);
        run_full(4'h8, 1'b1, 1'b0);
        run_full(4'hA, 1'b1, 1'b1);

        // Clear pulse in the middle of LDA's T3
        run_instr(4'h1, 1'b0, 1'b0, 3);
        #1;
        check_int("lda_t3_step", int'(bus.o_STEP), 3);
        check_str("lda_t3_lines", observed(), "RAM_OUT A_IN");
        #1 i_CLEAR = 1'b1;
        #1;
        check_int("clear_mid_step", int'(bus.o_STEP), 0);
        check_str("clear_mid_lines", observed(), "PC_OUT MAR_IN");
        @(negedge i_CLOCK);
        check_int("clear_hold_step", int'(bus.o_STEP), 0);
        i_CLEAR = 1'b0;

        // Random instruction stream (no HLT)
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 14));
            run_full(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // HLT: frozen at T2 for 20 cycles regardless of opcode, then clear
        run_instr(4'hF, 1'b0, 1'b0, 3);
        for (int i = 0; i < 20; i++) begin
            bus.i_OPCODE = 4'($urandom_range(0, 15));
            #1;
            check_int("halt_step", int'(bus.o_STEP), 2);
            check_str("halt_lines", observed(), "HALT");
            check_bus("halt");
            @(negedge i_CLOCK);
        end
        #2 i_CLEAR = 1'b1;
        #1;
        check_int("halt_clear_step", int'(bus.o_STEP), 0);
        check_str("halt_clear_lines", observed(), "PC_OUT MAR_IN");
        @(negedge i_CLOCK);
        i_CLEAR = 1'b0;

        // Normal execution resumes after leaving halt
        run_full(4'h5, 1'b0, 1'b0);
        run_full(4'hE, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
